// File: rtl/cam_capture_ctrl.sv
// Camera frame-capture sequencer: arms on a frame boundary, packs accepted pixel
// bytes four-per-word and streams them into the frame buffer with status flags.
module cam_capture_ctrl #(
  parameter int   IMG_W         = 160,
  parameter int   IMG_H         = 120,
  parameter int   ADDR_WIDTH    = 13,
  parameter logic VS_FRAME_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_dat,
  output logic                  cam_dat_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  short_line,
  output logic                  short_frame
);

  localparam int COL_W  = $clog2(IMG_W + 1);
  localparam int LINE_W = $clog2(IMG_H + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_W);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(IMG_H);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GAP,
    WAIT_SOF,
    CAPTURE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  href_q, href_d;
  logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
  logic [LINE_W-1:0]     line_cnt_q, line_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           pack_q, pack_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  short_line_q, short_line_d;
  logic                  short_frame_q, short_frame_d;

  logic vs_active;
  logic accept;
  logic eol;

  assign vs_active = (cam_vsync == VS_FRAME_HIGH);
  assign accept    = (state_q == CAPTURE) && cam_href && vs_active &&
                     (col_cnt_q < COL_MAX) && (line_cnt_q < LINE_MAX);
  assign eol       = (state_q == CAPTURE) && href_q && !cam_href;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    href_d        = cam_href;
    col_cnt_d     = col_cnt_q;
    line_cnt_d    = line_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    pack_d        = pack_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    short_line_d  = short_line_q;
    short_frame_d = short_frame_q;

    // Address advances after the cycle in which it was presented with wr_en.
    if (wr_en_q) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = WAIT_GAP;
          col_cnt_d     = '0;
          line_cnt_d    = '0;
          byte_cnt_d    = '0;
          wr_addr_d     = '0;
          short_line_d  = 1'b0;
          short_frame_d = 1'b0;
        end
      end
      WAIT_GAP: if (!vs_active) state_d = WAIT_SOF;
      WAIT_SOF: if (vs_active)  state_d = CAPTURE;
      CAPTURE: begin
        if (accept) begin
          col_cnt_d = col_cnt_q + COL_W'(1);
          pack_d    = {cam_dat, pack_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = {cam_dat, pack_q};
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        // accept needs href high and eol needs href low, so they never coincide.
        if (eol) begin
          if (line_cnt_q < LINE_MAX) line_cnt_d = line_cnt_q + LINE_W'(1);
          col_cnt_d  = '0;
          byte_cnt_d = '0;
          if (col_cnt_q < COL_MAX) short_line_d = 1'b1;
        end
        if (line_cnt_d == LINE_MAX) begin
          state_d = DONE;
        end else if (!vs_active) begin
          state_d       = DONE;
          short_frame_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      href_q        <= 1'b0;
      col_cnt_q     <= '0;
      line_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      pack_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      short_line_q  <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      href_q        <= href_d;
      col_cnt_q     <= col_cnt_d;
      line_cnt_q    <= line_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      pack_q        <= pack_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      short_line_q  <= short_line_d;
      short_frame_q <= short_frame_d;
    end
  end

  // IO-register enable depends on state alone so it is glitch-free and early.
  assign cam_dat_en  = (state_q == WAIT_SOF) || (state_q == CAPTURE);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign short_line  = short_line_q;
  assign short_frame = short_frame_q;

endmodule
